// File: rtl/alu_multdiv.sv
// alu_multdiv: iterative MULT/MULTU/DIV/DIVU into HI/LO, done WIDTH+2 cycles after accept (1 cycle for divide-by-zero).
// start is ignored while busy, no queuing; ALU_MULTDIV_EARLY_OUT_EN lets multiplies leave CALC once the multiplier is exhausted.
module alu_multdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               div_op_q, div_op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   shf_q, shf_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic             in_div;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign in_div    = op[1];
    assign in_signed = ~op[0];
    assign a_neg     = in_signed & portA[WIDTH-1];
    assign b_neg     = in_signed & portB[WIDTH-1];
    assign a_mag     = a_neg ? -portA : portA;
    assign b_mag     = b_neg ? -portB : portB;
    assign b_zero    = (portB == '0);

    // Multiply: opnd_q is the multiplicand, shf_q the multiplier shifting out LSB-first.
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign mul_addend = shf_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_step   = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: opnd_q is the divisor, shf_q shifts the dividend out MSB-first and the quotient in;
    // the partial remainder lives in acc_q[WIDTH:0].
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_qbit;
    logic [WIDTH:0]   div_rem;

    assign div_shift = {acc_q[WIDTH-1:0], shf_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_qbit  = ~div_diff[WIDTH+1];
    assign div_rem   = div_qbit ? div_diff[WIDTH:0] : div_shift;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -shf_q : shf_q;
    assign rem_fix  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

`ifdef ALU_MULTDIV_EARLY_OUT_EN
    logic             mul_rest_zero;
    logic [CNT_W-1:0] align_sh;

    assign mul_rest_zero = (shf_q[WIDTH-1:1] == '0);
    assign align_sh      = LAST_STEP - cnt_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (in_div && b_zero) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
`ifdef ALU_MULTDIV_EARLY_OUT_EN
                end else if (!div_op_q && mul_rest_zero) begin
                    state_d = S_FIX;
`endif
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        div_op_d   = div_op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        shf_d      = shf_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_op_d   = in_div;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    cnt_d      = '0;
                    acc_d      = '0;
                    div_zero_d = 1'b0;
                    if (in_div) begin
                        opnd_d = b_mag;
                        shf_d  = a_mag;
                    end else begin
                        opnd_d = a_mag;
                        shf_d  = b_mag;
                    end
                    if (in_div && b_zero) begin
                        hi_d       = portA;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (div_op_q) begin
                    acc_d = {{(WIDTH-1){1'b0}}, div_rem};
                    shf_d = {shf_q[WIDTH-2:0], div_qbit};
                end else begin
                    acc_d = mul_step;
                    shf_d = {1'b0, shf_q[WIDTH-1:1]};
`ifdef ALU_MULTDIV_EARLY_OUT_EN
                    // Nothing left to add: apply the remaining right shifts in one go.
                    if (mul_rest_zero) begin
                        acc_d = mul_step >> align_sh;
                    end
`endif
                end
            end
            S_FIX: begin
                if (div_op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_op_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            opnd_q     <= '0;
            shf_q      <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            div_op_q   <= div_op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            shf_q      <= shf_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divZero = div_zero_q;

endmodule

// File: tb/tb_alu_multdiv.sv
// Directed-vector bench for alu_multdiv at WIDTH=32: results, latency, handshake and async reset.
module tb_alu_multdiv;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] portA;
    logic [31:0] portB;
    logic        busy;
    logic        done;
    logic        divZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_bad   = 0;

    logic        dz0;
    logic [31:0] hi0, lo0, hi5, lo5;
    int          lat, pulses, busy_cyc, n_dn;

    alu_multdiv #(.WIDTH(32)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .op      (op),
        .portA   (portA),
        .portB   (portB),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge. Accepts one op at the next edge (E0) and then watches
    // 40 further edges, sampling 1 time unit after each. inject_at>0 re-pulses start so it is
    // sampled at edge E<inject_at>.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at);
        op    = o;
        portA = a;
        portB = b;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start    = 1'b0;
        lat      = -1;
        pulses   = 0;
        busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                pulses++;
                if (lat < 0) lat = i;
            end
            if (busy) busy_cyc++;
            if (i == 0) begin
                dz0 = divZero;
                hi0 = hi;
                lo0 = lo;
            end
            if (i == 5) begin
                hi5 = hi;
                lo5 = lo;
            end
            if (inject_at > 0 && i == inject_at - 1) begin
                start = 1'b1;
                op    = 2'b01;
                portA = 32'd1;
                portB = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        portA = '0;
        portB = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_divzero", divZero, 0);
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // MULT -3 x 7
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 0);
        check_val("mult_neg_hi", hi, 64'hFFFFFFFF);
        check_val("mult_neg_lo", lo, 64'hFFFFFFEB);
        check_val("mult_neg_lat", lat, 33);
        check_val("mult_neg_pulses", pulses, 1);
        check_val("mult_neg_busy", busy_cyc, 34);
        check_val("mult_neg_hold_hi", hi5, 0);

        // MULTU max x max
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check_val("multu_max_hi", hi, 64'hFFFFFFFE);
        check_val("multu_max_lo", lo, 64'h00000001);
        check_val("multu_max_hold_hi", hi5, 64'hFFFFFFFF);
        check_val("multu_max_hold_lo", lo5, 64'hFFFFFFEB);

        // MULTU 3 x 5
        run_op(2'b01, 32'd3, 32'd5, 0);
        check_val("multu_3x5_hi", hi, 0);
        check_val("multu_3x5_lo", lo, 64'h0000000F);
        check_val("multu_3x5_pulses", pulses, 1);
`ifdef ALU_MULTDIV_EARLY_OUT_EN
        check_val("multu_3x5_early", (lat >= 0 && lat < 33) ? 1 : 0, 1);
`else
        check_val("multu_3x5_lat", lat, 33);
`endif

        // DIV -7 / 2
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
        check_val("div_neg_lo", lo, 64'hFFFFFFFD);
        check_val("div_neg_hi", hi, 64'hFFFFFFFF);
        check_val("div_neg_lat", lat, 33);

        // DIV MIN / -1 wraps
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        check_val("div_min_lo", lo, 64'h80000000);
        check_val("div_min_hi", hi, 0);
        check_val("div_min_dz", divZero, 0);

        // DIVU 100 / 0
        run_op(2'b11, 32'd100, 32'd0, 0);
        check_val("divz_hi", hi, 64'h00000064);
        check_val("divz_lo", lo, 64'hFFFFFFFF);
        check_val("divz_dz", divZero, 1);
        check_val("divz_lat", lat, 0);
        check_val("divz_pulses", pulses, 1);
        check_val("divz_busy", busy_cyc, 1);
        check_val("divz_dz_held", divZero, 1);

        // DIVU 100 / 7: divZero clears at accept, HI/LO hold through CALC
        run_op(2'b11, 32'd100, 32'd7, 0);
        check_val("divu_dz_accept", dz0, 0);
        check_val("divu_hold_hi", hi0, 64'h00000064);
        check_val("divu_hold_lo", lo0, 64'hFFFFFFFF);
        check_val("divu_lo", lo, 64'h0000000E);
        check_val("divu_hi", hi, 64'h00000002);
        check_val("divu_lat", lat, 33);

        // MULT 6 x -2 with a stray start at E5
        run_op(2'b00, 32'd6, 32'hFFFFFFFE, 5);
        check_val("inj_pulses", pulses, 1);
        check_val("inj_lat", lat, 33);
        check_val("inj_hold_hi", hi5, 64'h00000002);
        check_val("inj_hold_lo", lo5, 64'h0000000E);
        check_val("inj_hi", hi, 64'hFFFFFFFF);
        check_val("inj_lo", lo, 64'hFFFFFFF4);
        check_val("inj_idle", busy, 0);

        // Asynchronous reset in the middle of CALC
        op    = 2'b01;
        portA = 32'd9;
        portB = 32'd9;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        #2;
        check_val("pre_rst_busy", busy, 1);
        #1;
        RST = 1'b1;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_hi", hi, 0);
        check_val("arst_lo", lo, 0);
        check_val("arst_dz", divZero, 0);
        n_dn = 0;
        if (done) n_dn++;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (done) n_dn++;
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        if (done) n_dn++;
        check_val("arst_no_done", n_dn, 0);

        run_op(2'b01, 32'd2, 32'd3, 0);
        check_val("post_rst_lo", lo, 64'h00000006);
        check_val("post_rst_hi", hi, 0);
        check_val("post_rst_lat", lat, 33);
        check_val("post_rst_pulses", pulses, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
